// File: rtl/ibex_branch_resolve_pkg.sv
// ibex_branch_resolve_pkg
// Shared types and helpers for the branch-resolution block.
//   bp_rec_t        : one prediction record captured at fetch
//   br_res_state_e  : resolver state (IDLE / RUN / RECOVER)
//   BpRecZero       : all-zero record used for storage reset
//   seq_pc()        : sequential next PC of an instruction, modulo 2^32
package ibex_branch_resolve_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        compressed;
  } bp_rec_t;

  typedef enum logic [1:0] {
    BR_IDLE    = 2'd0,
    BR_RUN     = 2'd1,
    BR_RECOVER = 2'd2
  } br_res_state_e;

  localparam bp_rec_t BpRecZero = '{
    pc:         32'h0000_0000,
    taken:      1'b0,
    target:     32'h0000_0000,
    compressed: 1'b0
  };

  // Fall-through PC: 16-bit instructions advance by 2, 32-bit ones by 4.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc, input logic compressed);
    return pc + (compressed ? 32'd2 : 32'd4);
  endfunction

endpackage

// File: rtl/ibex_branch_resolve_fifo.sv
// ibex_branch_resolve_fifo
// In-order queue of prediction records between IF and EX.
//   clk_i / rst_ni  : clock, synchronous active-low reset
//   clear_i         : drop every entry (dominates push/pop)
//   push_i, rec_i   : append a record (caller guarantees !full)
//   pop_i           : retire the head record (caller guarantees !empty)
//   head_o          : oldest record
//   full_o/empty_o  : queue status
//   occupancy_o     : number of entries held
module ibex_branch_resolve_fifo
  import ibex_branch_resolve_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned AW    = $clog2(Depth),
  localparam int unsigned OccW  = AW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  bp_rec_t         rec_i,
  input  logic            pop_i,
  output bp_rec_t         head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [OccW-1:0] occupancy_o
);

  localparam logic [AW:0] PtrOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PtrZero = {(AW+1){1'b0}};

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  bp_rec_t     mem_q [Depth];

  // Next pointer values: clear wins, otherwise advance on push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = PtrZero;
      rptr_d = PtrZero;
    end else begin
      if (push_i) begin
        wptr_d = wptr_q + PtrOne;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_i) begin
        rptr_d = rptr_q + PtrOne;
      end else begin
        rptr_d = rptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= PtrZero;
      rptr_q <= PtrZero;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Record storage; a push coinciding with clear is wrong-path and not written.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= BpRecZero;
      end
    end else if (push_i && !clear_i) begin
      mem_q[wptr_q[AW-1:0]] <= rec_i;
    end
  end

  assign head_o      = mem_q[rptr_q[AW-1:0]];
  assign empty_o     = (wptr_q == rptr_q);
  assign full_o      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign occupancy_o = wptr_q - rptr_q;

endmodule

// File: rtl/ibex_branch_resolve_sva.sv
// ibex_branch_resolve_sva
// Protocol checker for ibex_branch_resolve.
//   occupancy_i  : entries held by the queue
//   mispredict_i : registered mispredict pulse
//   push_i       : record actually written this cycle
//   ready_i/full_i : acceptance state seen by fetch
module ibex_branch_resolve_sva #(
  parameter  int unsigned Depth = 4,
  localparam int unsigned OccW  = $clog2(Depth) + 1
) (
  input logic            clk_i,
  input logic            rst_ni,
  input logic [OccW-1:0] occupancy_i,
  input logic            mispredict_i,
  input logic            push_i,
  input logic            ready_i,
  input logic            full_i
);

  localparam logic [OccW-1:0] DepthOcc = OccW'(Depth);

  a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    occupancy_i <= DepthOcc)
    else $error("occupancy exceeds queue depth");

  a_mispred_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mispredict_i |=> !mispredict_i)
    else $error("mispredict held for two cycles");

  a_push_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_i |-> (ready_i && !full_i))
    else $error("record pushed while not ready");

endmodule

// File: rtl/ibex_branch_resolve.sv
// ibex_branch_resolve
// Resolution end of static branch prediction. Fetch pushes a record per predicted
// branch/jump; EX resolves them in order. The predicted next PC is compared with the
// actual next PC and a registered redirect is issued on mismatch.
//   pred_*_i / pred_ready_o : prediction record handshake from IF
//   res_*_i                 : resolution of the oldest record from EX
//   flush_i                 : discards all records, highest priority
//   mispredict_o, redirect_pc_o : one-cycle redirect pulse and target (target held)
//   resolve_err_o           : resolve with empty queue or PC not matching head
//   occupancy_o             : records held
//   perf_branch_o / perf_mispred_o : saturating event counters
module ibex_branch_resolve
  import ibex_branch_resolve_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  parameter  int unsigned CntW  = 32,
  localparam int unsigned OccW  = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pred_valid_i,
  output logic            pred_ready_o,
  input  logic [31:0]     pred_pc_i,
  input  logic            pred_taken_i,
  input  logic [31:0]     pred_target_i,
  input  logic            pred_compressed_i,
  input  logic            res_valid_i,
  input  logic [31:0]     res_pc_i,
  input  logic            res_taken_i,
  input  logic [31:0]     res_target_i,
  input  logic            flush_i,
  output logic            mispredict_o,
  output logic [31:0]     redirect_pc_o,
  output logic            resolve_err_o,
  output logic [OccW-1:0] occupancy_o,
  output logic [CntW-1:0] perf_branch_o,
  output logic [CntW-1:0] perf_mispred_o
);

  localparam logic [OccW-1:0] DepthOcc = OccW'(Depth);
  localparam logic [OccW-1:0] OccZero  = {OccW{1'b0}};
  localparam logic [OccW-1:0] OccOne   = {{(OccW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};
  localparam logic [CntW-1:0] CntOne   = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] CntZero  = {CntW{1'b0}};

  br_res_state_e   state_q, state_d;
  logic            ready_q, ready_d;
  logic            mispredict_q, mispredict_d;
  logic [31:0]     redirect_q, redirect_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_br_q, cnt_br_d;
  logic [CntW-1:0] cnt_mis_q, cnt_mis_d;

  bp_rec_t         push_rec_s, head_s;
  logic            fifo_full_s, fifo_empty_s;
  logic [OccW-1:0] occ_s, occ_next_s;
  logic            res_fire_s, pop_s, pc_mismatch_s, mispredict_s;
  logic            clear_s, push_s, err_s;
  logic [31:0]     pred_next_s, act_next_s;

  assign push_rec_s = '{
    pc:         pred_pc_i,
    taken:      pred_taken_i,
    target:     pred_target_i,
    compressed: pred_compressed_i
  };

  ibex_branch_resolve_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_s),
    .push_i      (push_s),
    .rec_i       (push_rec_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .occupancy_o (occ_s)
  );

  // Resolve compare. The actual fall-through uses the resolved PC, so a head/PC
  // mismatch still redirects to where the executed instruction really goes.
  always_comb begin
    res_fire_s    = res_valid_i && !flush_i;
    pop_s         = res_fire_s && !fifo_empty_s;
    pc_mismatch_s = pop_s && (res_pc_i != head_s.pc);
    pred_next_s   = head_s.taken ? head_s.target : seq_pc(head_s.pc, head_s.compressed);
    act_next_s    = res_taken_i ? res_target_i : seq_pc(res_pc_i, head_s.compressed);
    mispredict_s  = pop_s && (pc_mismatch_s || (pred_next_s != act_next_s));
    clear_s       = flush_i || mispredict_s;
    // Anything fetched alongside a flush or mispredict is wrong-path.
    push_s        = pred_valid_i && ready_q && !clear_s;
    err_s         = res_fire_s && (fifo_empty_s || pc_mismatch_s);
  end

  // Occupancy after this edge; feeds the registered ready and the FSM.
  always_comb begin
    occ_next_s = occ_s;
    if (clear_s) begin
      occ_next_s = OccZero;
    end else if (push_s && !pop_s) begin
      occ_next_s = occ_s + OccOne;
    end else if (pop_s && !push_s) begin
      occ_next_s = occ_s - OccOne;
    end else begin
      occ_next_s = occ_s;
    end
  end

  // Next state, ready, redirect and counter values.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = BR_IDLE;
    end else begin
      case (state_q)
        BR_IDLE: begin
          if (push_s) begin
            state_d = BR_RUN;
          end else begin
            state_d = BR_IDLE;
          end
        end
        BR_RUN: begin
          if (mispredict_s) begin
            state_d = BR_RECOVER;
          end else if (occ_next_s == OccZero) begin
            state_d = BR_IDLE;
          end else begin
            state_d = BR_RUN;
          end
        end
        BR_RECOVER: state_d = BR_IDLE;
        default:    state_d = BR_IDLE;
      endcase
    end

    ready_d      = (occ_next_s != DepthOcc) && (state_d != BR_RECOVER);
    mispredict_d = mispredict_s;
    err_d        = err_s;

    if (mispredict_s) begin
      redirect_d = act_next_s;
    end else begin
      redirect_d = redirect_q;
    end

    if (pop_s && (cnt_br_q != CntMax)) begin
      cnt_br_d = cnt_br_q + CntOne;
    end else begin
      cnt_br_d = cnt_br_q;
    end

    if (mispredict_s && (cnt_mis_q != CntMax)) begin
      cnt_mis_d = cnt_mis_q + CntOne;
    end else begin
      cnt_mis_d = cnt_mis_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= BR_IDLE;
      ready_q      <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= 32'h0000_0000;
      err_q        <= 1'b0;
      cnt_br_q     <= CntZero;
      cnt_mis_q    <= CntZero;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      err_q        <= err_d;
      cnt_br_q     <= cnt_br_d;
      cnt_mis_q    <= cnt_mis_d;
    end
  end

  assign pred_ready_o   = ready_q;
  assign mispredict_o   = mispredict_q;
  assign redirect_pc_o  = redirect_q;
  assign resolve_err_o  = err_q;
  assign occupancy_o    = occ_s;
  assign perf_branch_o  = cnt_br_q;
  assign perf_mispred_o = cnt_mis_q;

  ibex_branch_resolve_sva #(
    .Depth (Depth)
  ) u_sva (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .occupancy_i  (occ_s),
    .mispredict_i (mispredict_q),
    .push_i       (push_s),
    .ready_i      (ready_q),
    .full_i       (fifo_full_s)
  );

endmodule

// File: tb/tb_ibex_branch_resolve.sv
// tb_ibex_branch_resolve
// Directed scenarios followed by a randomized run, all checked against a queue-based
// reference model of the prediction/resolution rules.
module tb_ibex_branch_resolve;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pred_valid_i = 1'b0;
  logic        pred_ready_o;
  logic [31:0] pred_pc_i = 32'h0;
  logic        pred_taken_i = 1'b0;
  logic [31:0] pred_target_i = 32'h0;
  logic        pred_compressed_i = 1'b0;
  logic        res_valid_i = 1'b0;
  logic [31:0] res_pc_i = 32'h0;
  logic        res_taken_i = 1'b0;
  logic [31:0] res_target_i = 32'h0;
  logic        flush_i = 1'b0;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic        resolve_err_o;
  logic [2:0]  occupancy_o;
  logic [31:0] perf_branch_o;
  logic [31:0] perf_mispred_o;

  ibex_branch_resolve #(.Depth(4), .CntW(32)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .pred_valid_i      (pred_valid_i),
    .pred_ready_o      (pred_ready_o),
    .pred_pc_i         (pred_pc_i),
    .pred_taken_i      (pred_taken_i),
    .pred_target_i     (pred_target_i),
    .pred_compressed_i (pred_compressed_i),
    .res_valid_i       (res_valid_i),
    .res_pc_i          (res_pc_i),
    .res_taken_i       (res_taken_i),
    .res_target_i      (res_target_i),
    .flush_i           (flush_i),
    .mispredict_o      (mispredict_o),
    .redirect_pc_o     (redirect_pc_o),
    .resolve_err_o     (resolve_err_o),
    .occupancy_o       (occupancy_o),
    .perf_branch_o     (perf_branch_o),
    .perf_mispred_o    (perf_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        c;
  } mrec_t;

  mrec_t       mq[$];
  logic        m_recover    = 1'b0;
  logic        m_rst_recent = 1'b1;
  logic [31:0] m_redirect   = 32'h0;
  logic        m_mis_o      = 1'b0;
  logic        m_err_o      = 1'b0;
  int          m_br         = 0;
  int          m_mis        = 0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return !m_rst_recent && (mq.size() < 4) && !m_recover;
  endfunction

  task automatic check_all();
    check("ready",    {31'd0, pred_ready_o},  {31'd0, m_ready()});
    check("occ",      {29'd0, occupancy_o},   32'(mq.size()));
    check("mispred",  {31'd0, mispredict_o},  {31'd0, m_mis_o});
    check("redirect", redirect_pc_o,          m_redirect);
    check("err",      {31'd0, resolve_err_o}, {31'd0, m_err_o});
    check("perf_br",  perf_branch_o,          32'(m_br));
    check("perf_mis", perf_mispred_o,         32'(m_mis));
  endtask

  // One clock of stimulus; the model is advanced with the same rules, then all outputs compared.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic ptk,
                      input logic [31:0] ptgt, input logic pcmp,
                      input logic rv, input logic [31:0] rpc, input logic rtk,
                      input logic [31:0] rtgt, input logic fl);
    logic        push, mis, err;
    logic [31:0] pn, an;
    mrec_t       h;
    pred_valid_i = pv; pred_pc_i = ppc; pred_taken_i = ptk;
    pred_target_i = ptgt; pred_compressed_i = pcmp;
    res_valid_i = rv; res_pc_i = rpc; res_taken_i = rtk; res_target_i = rtgt;
    flush_i = fl;
    push = pv && m_ready();
    mis = 1'b0; err = 1'b0; an = 32'h0;
    if (fl) begin
      mq.delete();
      m_recover = 1'b0;
    end else begin
      if (rv) begin
        if (mq.size() == 0) begin
          err = 1'b1;
        end else begin
          h = mq.pop_front();
          m_br++;
          pn = h.tk ? h.tgt : h.pc + (h.c ? 32'd2 : 32'd4);
          an = rtk ? rtgt : rpc + (h.c ? 32'd2 : 32'd4);
          if (rpc != h.pc) begin
            mis = 1'b1; err = 1'b1;
          end else if (pn != an) begin
            mis = 1'b1;
          end
        end
      end
      if (mis) begin
        mq.delete();
        m_redirect = an;
        m_mis++;
      end else if (push) begin
        mq.push_back('{ppc, ptk, ptgt, pcmp});
      end
      m_recover = mis;
    end
    m_rst_recent = 1'b0;
    m_mis_o = mis;
    m_err_o = err;
    @(posedge clk_i); #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic c);
    step(1'b1, pc, tk, tgt, c, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, pc, tk, tgt, 1'b0);
  endtask

  // Reset with busy inputs; everything must come out zero.
  task automatic do_reset();
    rst_ni = 1'b0;
    pred_valid_i = 1'b1; pred_pc_i = 32'h0000_0A00;
    res_valid_i = 1'b1; res_pc_i = 32'h0000_0A00; res_taken_i = 1'b1;
    flush_i = 1'b0;
    @(posedge clk_i); #1;
    mq.delete();
    m_recover = 1'b0; m_rst_recent = 1'b1; m_redirect = 32'h0;
    m_mis_o = 1'b0; m_err_o = 1'b0; m_br = 0; m_mis = 0;
    check_all();
    rst_ni = 1'b1;
    pred_valid_i = 1'b0; res_valid_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        pv, ptk, pc_c, rv, rtk, fl;
    logic [31:0] ppc, ptgt, rpc, rtgt;

    do_reset();
    idle();

    // 1: correctly predicted taken branch
    push(32'h100, 1'b1, 32'h0F0, 1'b0);
    res(32'h100, 1'b1, 32'h0F0);
    check("t1_perf_br", perf_branch_o, 32'd1);

    // 2: predicted not-taken (compressed), actually taken
    push(32'h200, 1'b0, 32'h0, 1'b1);
    res(32'h200, 1'b1, 32'h300);
    check("t2_redirect", redirect_pc_o, 32'h300);
    check("t2_ready", {31'd0, pred_ready_o}, 32'd0);
    idle();

    // 3: predicted taken, actually not-taken; 32-bit, 16-bit and address wrap
    push(32'h400, 1'b1, 32'h380, 1'b0);
    res(32'h400, 1'b0, 32'h380);
    check("t3_redirect4", redirect_pc_o, 32'h404);
    idle();
    push(32'h400, 1'b1, 32'h380, 1'b1);
    res(32'h400, 1'b0, 32'h380);
    check("t3_redirect2", redirect_pc_o, 32'h402);
    idle();
    push(32'hFFFF_FFFC, 1'b1, 32'h80, 1'b0);
    res(32'hFFFF_FFFC, 1'b0, 32'h80);
    check("t3_wrap", redirect_pc_o, 32'h0);
    idle();
    // not-taken/not-taken with differing targets is not a mispredict
    push(32'h480, 1'b0, 32'h111, 1'b0);
    res(32'h480, 1'b0, 32'h222);

    // 4: fill, blocked push, pop alone, steady push+pop
    for (int i = 1; i <= 4; i++) push(32'(i) * 32'h10, 1'b0, 32'h0, 1'b0);
    check("t4_occ_full", {29'd0, occupancy_o}, 32'd4);
    step(1'b1, 32'h50, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    check("t4_ready_after_pop", {31'd0, pred_ready_o}, 32'd1);
    step(1'b1, 32'h50, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
    check("t4_occ_steady", {29'd0, occupancy_o}, 32'd3);
    res(32'h30, 1'b0, 32'h0);
    res(32'h40, 1'b0, 32'h0);
    res(32'h50, 1'b0, 32'h0);

    // 5: mispredict with same-cycle push and older entries; flush masks mispredict
    push(32'h600, 1'b0, 32'h0, 1'b0);
    push(32'h610, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h620, 1'b0, 32'h0, 1'b0, 1'b1, 32'h600, 1'b1, 32'h700, 1'b0);
    check("t5_empty", {29'd0, occupancy_o}, 32'd0);
    idle();
    push(32'h630, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h640, 1'b0, 32'h0, 1'b0, 1'b1, 32'h630, 1'b1, 32'h900, 1'b1);
    check("t5_flush_nomis", {31'd0, mispredict_o}, 32'd0);

    // 6: resolve on empty, PC mismatch, reset mid-run
    res(32'h500, 1'b0, 32'h0);
    check("t6_err_empty", {31'd0, resolve_err_o}, 32'd1);
    push(32'h500, 1'b0, 32'h0, 1'b0);
    res(32'h504, 1'b1, 32'h600);
    check("t6_pcmis_err", {31'd0, resolve_err_o}, 32'd1);
    check("t6_pcmis_mis", {31'd0, mispredict_o}, 32'd1);
    idle();
    push(32'h700, 1'b0, 32'h0, 1'b0);
    push(32'h710, 1'b1, 32'h800, 1'b1);
    do_reset();
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pv   = 1'($urandom_range(0, 1));
      ppc  = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd2;
      ptk  = 1'($urandom_range(0, 1));
      ptgt = ($urandom_range(0, 1) == 0) ? 32'h2000 : 32'h3000;
      pc_c = 1'($urandom_range(0, 1));
      rtk  = 1'($urandom_range(0, 1));
      rtgt = ($urandom_range(0, 1) == 0) ? 32'h2000 : 32'h3000;
      fl   = ($urandom_range(0, 24) == 0);
      if (mq.size() > 0) begin
        rv  = 1'($urandom_range(0, 1));
        rpc = mq[0].pc;
        if ($urandom_range(0, 15) == 0) begin
          rpc = mq[0].pc + 32'd4;
          rtk = 1'b1;
        end
      end else begin
        rv  = ($urandom_range(0, 7) == 0);
        rpc = ppc;
      end
      step(pv, ppc, ptk, ptgt, pc_c, rv, rpc, rtk, rtgt, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
